// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared constants and state encoding for the store buffer
package sb_pkg;
   localparam int SB_DEPTH_DEFAULT = 4;
   // Word index is addr[AW-1:SB_WORD_LSB]; byte offset bits never take part in matching.
   localparam int SB_WORD_LSB = 2;

   typedef enum logic {
      SB_RUN   = 1'b0,
      SB_FENCE = 1'b1
   } sb_state_e;
endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest-match priority scan of buffered store word indices
module sb_fwd_match
   import sb_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEFAULT,
   parameter int WW    = 30,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]         valid,
   input  logic [DEPTH-1:0][WW-1:0] words,
   input  logic [WW-1:0]            ld_word,
   input  logic [PW-1:0]            wr_ptr,
   output logic                     hit,
   output logic [PW-1:0]            index
);

   // Walk from the oldest slot (wr_ptr) to the youngest (wr_ptr-1); later hits overwrite earlier.
   always_comb begin
      hit   = 1'b0;
      index = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (valid[wr_ptr - PW'(k)] && (words[wr_ptr - PW'(k)] == ld_word)) begin
            hit   = 1'b1;
            index = wr_ptr - PW'(k);
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store FIFO with load forwarding and fence
module store_buffer
   import sb_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEFAULT,
   parameter int AW    = 32,
   parameter int DW    = 32,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1,
   localparam int WW   = AW - SB_WORD_LSB
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   output logic          st_ready,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   output logic [DW-1:0] ld_data,
   output logic          ld_fwd,
   input  logic          fence,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_write,
   output logic          mem_read,
   input  logic [DW-1:0] mem_rdata,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [DEPTH-1:0][AW-1:0] addr_q;
   logic [DEPTH-1:0][DW-1:0] data_q;
   logic [DEPTH-1:0][WW-1:0] words;
   logic [DEPTH-1:0]         valid_q;
   logic [PW-1:0]            wr_ptr, rd_ptr, hit_idx;
   logic                     hit, full, push, pop, load_miss;
   sb_state_e                state, state_next;

   always_comb begin
      words = '0;
      for (int i = 0; i < DEPTH; i++) begin
         words[i] = addr_q[i][AW-1:SB_WORD_LSB];
      end
   end

   sb_fwd_match #(.DEPTH(DEPTH), .WW(WW)) u_match (
      .valid   (valid_q),
      .words   (words),
      .ld_word (ld_addr[AW-1:SB_WORD_LSB]),
      .wr_ptr  (wr_ptr),
      .hit     (hit),
      .index   (hit_idx)
   );

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign st_ready  = (state == SB_RUN) && !full;
   assign push      = st_valid && st_ready;
   assign load_miss = ld_req && !hit;
   // A missing load owns the memory port, so the drain waits for it.
   assign pop       = !empty && !load_miss;
   assign ld_fwd    = ld_req && hit;
   assign ld_data   = !ld_req ? '0 : (hit ? data_q[hit_idx] : mem_rdata);

   always_comb begin
      state_next = state;
      case (state)
         SB_RUN:   if (fence) state_next = (empty && !push) ? SB_RUN : SB_FENCE;
         SB_FENCE: if (empty) state_next = SB_RUN;
         default:  state_next = SB_RUN;
      endcase
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      if (load_miss) begin
         mem_read = 1'b1;
         mem_addr = ld_addr;
      end else if (!empty) begin
         mem_write = 1'b1;
         mem_addr  = addr_q[rd_ptr];
         mem_wdata = data_q[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= SB_RUN;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         valid_q <= '0;
      end else begin
         state <= state_next;
         if (push) begin
            valid_q[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            valid_q[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= st_addr;
         data_q[wr_ptr] <= st_data;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, st_valid, st_ready, ld_req, ld_fwd, fence;
   logic        mem_write, mem_read, empty;
   logic [31:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wdata;
   wire  [31:0] mem_rdata;
   logic [2:0]  count;
   logic [31:0] mem [0:1023];
   logic        mem_ready = 1'b0;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .st_ready(st_ready), .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_fwd(ld_fwd), .fence(fence), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
      .count(count), .empty(empty)
   );

   // Word-addressed data memory: write on the clock edge, combinational read, Z when idle.
   assign mem_rdata = mem_read ? mem[mem_addr[11:2]] : 'z;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 + i;
         mem_ready <= 1'b1;
      end else if (mem_write) begin
         mem[mem_addr[11:2]] <= mem_wdata;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 16 && empty !== 1'b1; i++) tick();
      total_cnt++; if (empty !== 1'b1) $display("FAIL %s_drain: empty=%b want 1", name, empty); else pass_cnt++;
   endtask

   task automatic test_reset;
      rst = 1'b0; st_valid = 0; st_addr = 0; st_data = 0; ld_req = 0; ld_addr = 0; fence = 0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if ({count, empty, st_ready} !== {3'd0, 1'b1, 1'b1}) $display("FAIL reset_status: count=%0d empty=%b st_ready=%b want 0 1 1", count, empty, st_ready); else pass_cnt++;
      total_cnt++; if ({mem_write, mem_read, ld_fwd} !== 3'b000) $display("FAIL reset_mem: write=%b read=%b fwd=%b want 000", mem_write, mem_read, ld_fwd); else pass_cnt++;
      total_cnt++; if (ld_data !== 32'd0) $display("FAIL reset_ld_data: got %h want 0", ld_data); else pass_cnt++;
      rst = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         st_valid = 1; st_addr = 2000 + 4 * i; st_data = 32'hDEAD_0000 + i; ld_req = 1; ld_addr = 4000;
         tick();
      end
      st_valid = 0; ld_req = 0;
      #1;
      total_cnt++; if ({count, mem_write} !== {3'd3, 1'b1}) $display("FAIL reset_prefill: count=%0d write=%b want 3 1", count, mem_write); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++; if ({count, empty, mem_write} !== {3'd0, 1'b1, 1'b0}) $display("FAIL reset_middrain: count=%0d empty=%b write=%b want 0 1 0", count, empty, mem_write); else pass_cnt++;
      tick();
      rst = 1'b1;
      #1;
      total_cnt++; if (mem[500] !== 32'hA5A5_01F4) $display("FAIL reset_mem500: got %h want a5a501f4", mem[500]); else pass_cnt++;
   endtask

   task automatic test_drain;
      st_valid = 1; st_addr = 2000; st_data = 5;
      tick();
      st_addr = 2004; st_data = 6;
      #1;
      total_cnt++; if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 32'd2000, 32'd5}) $display("FAIL drain_w0: write=%b addr=%0d data=%0d want 1 2000 5", mem_write, mem_addr, mem_wdata); else pass_cnt++;
      tick();
      st_addr = 2008; st_data = 7;
      #1;
      total_cnt++; if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 32'd2004, 32'd6}) $display("FAIL drain_w1: write=%b addr=%0d data=%0d want 1 2004 6", mem_write, mem_addr, mem_wdata); else pass_cnt++;
      tick();
      st_valid = 0;
      #1;
      total_cnt++; if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 32'd2008, 32'd7}) $display("FAIL drain_w2: write=%b addr=%0d data=%0d want 1 2008 7", mem_write, mem_addr, mem_wdata); else pass_cnt++;
      tick();
      total_cnt++; if ({empty, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b0, 64'd0}) $display("FAIL drain_idle: empty=%b write=%b addr=%0d data=%0d want 1 0 0 0", empty, mem_write, mem_addr, mem_wdata); else pass_cnt++;
      total_cnt++; if ({mem[500], mem[501], mem[502]} !== {32'd5, 32'd6, 32'd7}) $display("FAIL drain_mem: got %0d %0d %0d want 5 6 7", mem[500], mem[501], mem[502]); else pass_cnt++;
   endtask

   task automatic test_forward;
      st_valid = 1; st_addr = 2000; st_data = 9; ld_req = 1; ld_addr = 4000;
      tick();
      st_data = 11;
      tick();
      st_data = 13; ld_addr = 2003;
      #1;
      total_cnt++; if ({ld_fwd, ld_data, mem_read} !== {1'b1, 32'd11, 1'b0}) $display("FAIL fwd_youngest: fwd=%b data=%0d read=%b want 1 11 0", ld_fwd, ld_data, mem_read); else pass_cnt++;
      total_cnt++; if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 32'd2000, 32'd9}) $display("FAIL fwd_drain: write=%b addr=%0d data=%0d want 1 2000 9", mem_write, mem_addr, mem_wdata); else pass_cnt++;
      tick();
      st_valid = 0; ld_req = 0;
      #1;
      total_cnt++; if ({count, ld_data, ld_fwd} !== {3'd2, 32'd0, 1'b0}) $display("FAIL fwd_after: count=%0d data=%0d fwd=%b want 2 0 0", count, ld_data, ld_fwd); else pass_cnt++;
      drain("fwd");
      total_cnt++; if (mem[500] !== 32'd13) $display("FAIL fwd_mem: got %0d want 13", mem[500]); else pass_cnt++;
   endtask

   task automatic test_miss;
      st_valid = 1; st_addr = 2012; st_data = 21; ld_req = 1; ld_addr = 4000;
      tick();
      st_addr = 2016; st_data = 22;
      tick();
      st_valid = 0;
      #1;
      total_cnt++; if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 32'd4000}) $display("FAIL miss_port: read=%b write=%b addr=%0d want 1 0 4000", mem_read, mem_write, mem_addr); else pass_cnt++;
      total_cnt++; if ({ld_data, ld_fwd, count} !== {32'hA5A5_03E8, 1'b0, 3'd2}) $display("FAIL miss_data: data=%h fwd=%b count=%0d want a5a503e8 0 2", ld_data, ld_fwd, count); else pass_cnt++;
      tick();
      ld_req = 0;
      #1;
      total_cnt++; if ({count, mem_write, mem_addr, mem_wdata} !== {3'd2, 1'b1, 32'd2012, 32'd21}) $display("FAIL miss_resume: count=%0d write=%b addr=%0d data=%0d want 2 1 2012 21", count, mem_write, mem_addr, mem_wdata); else pass_cnt++;
      drain("miss");
      total_cnt++; if ({mem[503], mem[504]} !== {32'd21, 32'd22}) $display("FAIL miss_mem: got %0d %0d want 21 22", mem[503], mem[504]); else pass_cnt++;
   endtask

   task automatic test_full;
      ld_req = 1; ld_addr = 4000;
      for (int i = 0; i < DEPTH; i++) begin
         st_valid = 1; st_addr = 2040 + 4 * i; st_data = 100 + i;
         #1;
         total_cnt++; if (st_ready !== 1'b1) $display("FAIL full_fill%0d: st_ready=%b want 1", i, st_ready); else pass_cnt++;
         tick();
      end
      st_addr = 2040; st_data = 104;
      #1;
      total_cnt++; if ({st_ready, count} !== {1'b0, 3'd4}) $display("FAIL full_block: st_ready=%b count=%0d want 0 4", st_ready, count); else pass_cnt++;
      tick();
      ld_req = 0;
      #1;
      total_cnt++; if ({st_ready, mem_write, count} !== {1'b0, 1'b1, 3'd4}) $display("FAIL full_nobypass: st_ready=%b write=%b count=%0d want 0 1 4", st_ready, mem_write, count); else pass_cnt++;
      tick();
      total_cnt++; if ({st_ready, count} !== {1'b1, 3'd3}) $display("FAIL full_reopen: st_ready=%b count=%0d want 1 3", st_ready, count); else pass_cnt++;
      tick();
      st_valid = 0;
      #1;
      total_cnt++; if (count !== 3'd3) $display("FAIL full_pushpop: count=%0d want 3", count); else pass_cnt++;
      drain("full");
      total_cnt++; if ({mem[510], mem[511], mem[512], mem[513]} !== {32'd104, 32'd101, 32'd102, 32'd103}) $display("FAIL full_order: got %0d %0d %0d %0d want 104 101 102 103", mem[510], mem[511], mem[512], mem[513]); else pass_cnt++;
   endtask

   task automatic test_fence;
      ld_req = 1; ld_addr = 4000;
      for (int i = 0; i < 3; i++) begin
         st_valid = 1; st_addr = 2080 + 4 * i; st_data = 30 + i;
         tick();
      end
      st_valid = 0; ld_req = 0; fence = 1;
      tick();
      fence = 0; st_valid = 1; st_addr = 2092; st_data = 40;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++; if ({st_ready, count} !== {1'b0, 3'(2 - i)}) $display("FAIL fence_hold%0d: st_ready=%b count=%0d want 0 %0d", i, st_ready, count, 2 - i); else pass_cnt++;
         tick();
      end
      #1;
      total_cnt++; if ({st_ready, count} !== {1'b1, 3'd0}) $display("FAIL fence_release: st_ready=%b count=%0d want 1 0", st_ready, count); else pass_cnt++;
      tick();
      st_valid = 0;
      #1;
      total_cnt++; if (count !== 3'd1) $display("FAIL fence_accept: count=%0d want 1", count); else pass_cnt++;
      drain("fence");
      total_cnt++; if ({mem[522], mem[523]} !== {32'd32, 32'd40}) $display("FAIL fence_mem: got %0d %0d want 32 40", mem[522], mem[523]); else pass_cnt++;
      fence = 1;
      #1;
      total_cnt++; if (st_ready !== 1'b1) $display("FAIL fence_empty0: st_ready=%b want 1", st_ready); else pass_cnt++;
      tick();
      fence = 0;
      #1;
      total_cnt++; if (st_ready !== 1'b1) $display("FAIL fence_empty1: st_ready=%b want 1", st_ready); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_drain();
      test_forward();
      test_miss();
      test_full();
      test_fence();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1);
   end

endmodule
